// File: rtl/ifetch.sv
// Instruction-fetch stage: holds the PC, drives the synchronous instruction RAM and
// selects the next PC. Define IFETCH_PEND_REDIRECT_EN to keep branch redirects seen early.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [31:0] inst,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    output logic [31:0] inst_addr,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic {
        S_REQ,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        fetch_go;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];
    assign exc_valid  = exc_bus[32];
    assign exc_pc     = exc_bus[31:0];

    assign IF_over  = IF_valid & (state == S_DONE);
    assign fetch_go = IF_over & next_fetch;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (exc_valid) begin
            pc_nxt    = exc_pc;
            state_nxt = S_REQ;
        end else if (fetch_go) begin
            if (jbr_taken) begin
                pc_nxt = jbr_target;
            end else if (pend_valid) begin
                pc_nxt = pend_target;
            end else begin
                pc_nxt = pc + 32'd4;
            end
            state_nxt = S_REQ;
        end else if (state == S_REQ && IF_valid) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc    <= RESET_PC;
            state <= S_REQ;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
        end
    end

`ifdef IFETCH_PEND_REDIRECT_EN
    logic        pend_valid_nxt;
    logic [31:0] pend_target_nxt;

    // Any PC update consumes or discards the pending redirect.
    always_comb begin
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        if (exc_valid || fetch_go) begin
            pend_valid_nxt = 1'b0;
        end else if (jbr_taken) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = jbr_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end
`else
    assign pend_valid  = 1'b0;
    assign pend_target = 32'h0;
`endif

    assign inst_addr = pc;
    assign IF_ID_bus = {pc, inst};
    assign IF_pc     = pc;
    assign IF_inst   = inst;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios then random traffic, all checked against a
// transaction-level model of the fetch stage and a synchronous instruction RAM.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        IF_valid;
    logic        next_fetch;
    logic [31:0] inst;
    logic [32:0] jbr_bus;
    logic [32:0] exc_bus;
    logic [31:0] inst_addr;
    logic        IF_over;
    logic [63:0] IF_ID_bus;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    int checks = 0;
    int errors = 0;

    // Model: PC, whether the instruction for it has arrived, and pending redirect (0 or 1 entry).
    logic [31:0] m_pc;
    bit          m_have;
    logic [31:0] m_pend[$];

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .IF_valid  (IF_valid),
        .next_fetch(next_fetch),
        .inst      (inst),
        .jbr_bus   (jbr_bus),
        .exc_bus   (exc_bus),
        .inst_addr (inst_addr),
        .IF_over   (IF_over),
        .IF_ID_bus (IF_ID_bus),
        .IF_pc     (IF_pc),
        .IF_inst   (IF_inst)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) inst <= rom(inst_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_have = 1'b0;
        m_pend.delete();
    endtask

    // Drive one cycle's inputs, check outputs, advance model across the clock edge.
    task automatic step(input bit iv, input bit nf, input bit jt, input logic [31:0] jtgt,
                        input bit ev, input logic [31:0] epc);
        bit          over;
        logic [31:0] n_pc;
        bit          n_have;
        IF_valid   = iv;
        next_fetch = nf;
        jbr_bus    = {jt, jtgt};
        exc_bus    = {ev, epc};
        over       = iv && m_have;
        #1;
        check("if_over", {63'h0, IF_over}, {63'h0, over});
        check("inst_addr", {32'h0, inst_addr}, {32'h0, m_pc});
        check("if_pc", {32'h0, IF_pc}, {32'h0, m_pc});
        if (over) begin
            check("if_id_bus", IF_ID_bus, {m_pc, rom(m_pc)});
            check("if_inst", {32'h0, IF_inst}, {32'h0, rom(m_pc)});
        end
        n_pc   = m_pc;
        n_have = m_have;
        if (ev) begin
            n_pc   = epc;
            n_have = 1'b0;
            m_pend.delete();
        end else if (over && nf) begin
            if (jt) n_pc = jtgt;
            else if (m_pend.size() > 0) n_pc = m_pend[0];
            else n_pc = m_pc + 32'd4;
            n_have = 1'b0;
            m_pend.delete();
        end else begin
            n_have = m_have || iv;
`ifdef IFETCH_PEND_REDIRECT_EN
            if (jt) begin
                m_pend.delete();
                m_pend.push_back(jtgt);
            end
`endif
        end
        @(posedge clk);
        #1;
        m_pc   = n_pc;
        m_have = n_have;
    endtask

    initial begin
        logic [31:0] t1;
        logic [31:0] t2;
        resetn     = 1'b0;
        IF_valid   = 1'b0;
        next_fetch = 1'b0;
        jbr_bus    = 33'h0;
        exc_bus    = 33'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_over", {63'h0, IF_over}, 64'h0);
        check("reset_addr", {32'h0, inst_addr}, {32'h0, RST_PC});
        resetn = 1'b1;

        // Sequential fetch from reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("seq_addr4", {32'h0, inst_addr}, 64'h4);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("seq_addr8", {32'h0, inst_addr}, 64'h8);

        // Branch with honoured next_fetch
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h100, 0, 0);
        check("jbr_addr", {32'h0, inst_addr}, 64'h100);

        // Branch seen while IF_over=0, fetch two cycles later
        step(1, 0, 1, 32'h200, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
`ifdef IFETCH_PEND_REDIRECT_EN
        check("pend_addr", {32'h0, inst_addr}, 64'h200);
`else
        check("nopend_addr", {32'h0, inst_addr}, 64'h104);
`endif

        // Exception beats branch in S_REQ; pending must be empty afterwards
        step(1, 0, 1, 32'h300, 1, 32'h8);
        check("exc_addr", {32'h0, inst_addr}, 64'h8);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("exc_nopend", {32'h0, inst_addr}, 64'hC);

        // PC wrap
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("wrap_addr", {32'h0, inst_addr}, 64'h0);

        // IF_valid low holds S_REQ, then masks IF_over in S_DONE
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("ifvalid_addr", {32'h0, inst_addr}, 64'h4);

        // Asynchronous reset in S_DONE with a pending redirect
        step(1, 0, 1, 32'h400, 0, 0);
        resetn = 1'b0;
        #1;
        check("arst_over", {63'h0, IF_over}, 64'h0);
        check("arst_addr", {32'h0, inst_addr}, {32'h0, RST_PC});
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("arst_nopend", {32'h0, inst_addr}, 64'h4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            t1 = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 1023), 2'b00};
            t2 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 1023), 2'b00};
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, t1, $urandom_range(0, 19) == 0, t2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. Holds the PC, drives the synchronous instruction RAM address, and tracks its one-cycle read latency. Presents `{pc, inst}` on the 64-bit IF→ID bus and signals completion with `IF_over`. Selects the next PC from exception redirect, branch/jump redirect, a latched pending redirect, or sequential PC+4.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1: pipeline clock; all state on rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `IF_valid`  in  1: stage holds a live fetch (from pipeline control).
- `next_fetch`  in  1: ID accepted the current instruction; advance PC.
- `inst`  in  32: instruction RAM read data, valid one cycle after `inst_addr` changes.
- `jbr_bus`  in  33: `{jbr_taken, jbr_target[31:0]}` from decode.
- `exc_bus`  in  33: `{exc_valid, exc_pc[31:0]}` from writeback (syscall/eret redirect).
- `inst_addr`  out  32: instruction RAM address; equals `pc`.
- `IF_over`  out  1: instruction for current `pc` is valid.
- `IF_ID_bus`  out  64: `{pc, inst}`.
- `IF_pc`  out  32: display copy of `pc`.
- `IF_inst`  out  32: display copy of `inst`.

## Operation
- Registers: `pc[31:0]`, `state` ∈ {S_REQ, S_DONE}, `pend_valid`, `pend_target[31:0]`.
- S_REQ: address presented, RAM data not yet valid. If `IF_valid`=1, go to S_DONE next cycle. Otherwise stay.
- S_DONE: `IF_over = IF_valid`. Stays in S_DONE until a PC update.
- `IF_over = IF_valid & (state==S_DONE)`. It is 0 in S_REQ.
- `next_fetch` is honoured only when `IF_over`=1. When `IF_over`=0 it is ignored and no state changes.
- Next-PC priority on an honoured `next_fetch`:
  1. `exc_pc`
  2. `jbr_target` if `jbr_taken`
  3. `pend_target` if `pend_valid`
  4. `pc+4`
- On a PC update: `state`←S_REQ and `pend_valid`←0.
- `pc+4` wraps modulo 2^32. Target bits [1:0] are loaded unchanged. No alignment check.
- `exc_valid`=1 redirects unconditionally, in any state and regardless of `next_fetch` or `IF_valid`:
  - `pc`←`exc_pc`, `state`←S_REQ, `pend_valid`←0.
  - Exception beats any simultaneous `jbr_taken`.
- `jbr_taken`=1 without an honoured `next_fetch` (and no exception): `pend_valid`←1, `pend_target`←`jbr_target`. A later `jbr_taken` overwrites the pending target.
- `IF_ID_bus`, `IF_pc` and `IF_inst` are combinational from `pc` and `inst`. Decode samples them only while `IF_over`=1.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=S_REQ, `pend_valid`=0, `pend_target`=0. Hence `inst_addr`=`RESET_PC` and `IF_over`=0.
- No `next_fetch` is needed to fetch the first instruction.
- Fetch latency: `pc` update at edge N → `IF_over`=1 from cycle N+1, provided `IF_valid` stays 1.
- Sustained throughput: one instruction every 2 cycles (S_REQ, S_DONE).
- `inst_addr` changes only on the clock edge that updates `pc`. It never glitches mid-cycle.
- Reset mid-operation: all registers clear asynchronously. In-flight pending redirects are dropped. `IF_over` drops immediately.
- `IF_valid` falling in S_REQ holds S_REQ. `IF_valid` falling in S_DONE keeps S_DONE but forces `IF_over`=0.

## Configuration
- `IFETCH_PEND_REDIRECT_EN` defined: the pending-redirect register exists and behaves as in Operation.
- Not defined: `pend_valid`/`pend_target` are removed (tied to 0). `jbr_taken` is acted on only in the same cycle as an honoured `next_fetch`; at any other time it is ignored.
- Exception redirect is unaffected by the macro in both builds.

## Test plan
- Reset release, `IF_valid`=1, `next_fetch` pulsed every S_DONE → `inst_addr` sequence 0x0, 0x4, 0x8; `IF_over` toggles 0,1,0,1; `IF_ID_bus`={0x4, RAM[1]} while `IF_over`=1.
- `jbr_bus`={1, 0x0000_0100} coincident with `next_fetch` at pc=0x8 → next `inst_addr`=0x100; `pend_valid` stays 0.
- Macro defined: `jbr_bus`={1, 0x200} while `IF_over`=0, then `next_fetch` two cycles later → `pc`=0x200. Macro undefined, same stimulus → `pc`=previous+4.
- `exc_bus`={1, 0x0000_0008} and `jbr_bus`={1, 0x300} in the same cycle, state S_REQ, no `next_fetch` → `pc`=0x8, `state`=S_REQ, `pend_valid`=0.
- `pc`=0xFFFF_FFFC with honoured `next_fetch` → `pc` wraps to 0x0000_0000.
- `resetn` asserted low while in S_DONE with `pend_valid`=1 → same-cycle `IF_over`=0, `inst_addr`=`RESET_PC`, `pend_valid`=0.
